// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display sharing one external LUT.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl #(
    parameter int NDIG        = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iEN,
    input  logic                iLOAD,
    input  logic [4*NDIG-1:0]   iDATA,
    input  logic [NDIG-1:0]     iDP,
    output logic [3:0]          oDIG,
    input  logic [7:0]          iSEG,
    output logic [7:0]          oSEG,
    output logic [NDIG-1:0]     oSEL,
    output logic                oFRAME,
    output logic                oPEND
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               wrap_s, commit_s;
    logic [7:0]         seg_s;
    logic [NDIG-1:0]    sel_s;
    logic [4*NDIG-1:0]  stage_data_r, shadow_data_r;
    logic [NDIG-1:0]    stage_dp_r, shadow_dp_r;
    logic               pend_r;
    logic               seg_dp_unused_s;

    // The LUT's dp bit is replaced by our own decimal-point data.
    assign seg_dp_unused_s = iSEG[0];

`ifdef SEG7_LZ_BLANK_EN
    logic [NDIG-1:0] lz_s;

    function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] p);
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            run        = run & (d[4*k +: 4] == 4'h0) & ~p[k];
            lz_mask[k] = run;
        end
    endfunction

    assign lz_s = lz_mask(shadow_data_r, shadow_dp_r);
`else
`endif

    // Next-state logic for the scan FSM, slot counter and digit index
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        wrap_s   = 1'b0;
        commit_s = 1'b0;
        if (!iEN) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            idx_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s  = ST_BLANK;
                    cnt_s    = '0;
                    idx_s    = '0;
                    commit_s = 1'b1;
                end
                ST_BLANK: begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == BLANK_LAST) state_s = ST_SHOW;
                    else                     state_s = ST_BLANK;
                end
                ST_SHOW: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_s   = '0;
                        state_s = ST_BLANK;
                        if (idx_r == IDX_LAST) begin
                            idx_s    = '0;
                            wrap_s   = 1'b1;
                            commit_s = 1'b1;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    idx_s   = '0;
                end
            endcase
        end
    end

    // Pin values for the coming state; idx only moves on entry to BLANK, so idx_r is valid in SHOW
    always_comb begin
        seg_s = 8'hFF;
        sel_s = '1;
        if (state_s == ST_SHOW) begin
            sel_s[idx_r] = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            if (lz_s[idx_r]) seg_s = 8'hFF;
            else             seg_s = {iSEG[7:1], ~shadow_dp_r[idx_r]};
`else
            seg_s = {iSEG[7:1], ~shadow_dp_r[idx_r]};
`endif
        end else begin
            seg_s = 8'hFF;
        end
    end

    // Scan state and registered display pins
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            oSEG    <= 8'hFF;
            oSEL    <= '1;
            oFRAME  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            oSEG    <= seg_s;
            oSEL    <= sel_s;
            oFRAME  <= wrap_s;
        end
    end

    // Staging/shadow data; a load coinciding with a commit goes straight to the shadow
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stage_data_r  <= '0;
            stage_dp_r    <= '0;
            shadow_data_r <= '0;
            shadow_dp_r   <= '0;
            pend_r        <= 1'b0;
        end else if (commit_s) begin
            pend_r <= 1'b0;
            if (iLOAD) begin
                stage_data_r  <= iDATA;
                stage_dp_r    <= iDP;
                shadow_data_r <= iDATA;
                shadow_dp_r   <= iDP;
            end else if (pend_r) begin
                shadow_data_r <= stage_data_r;
                shadow_dp_r   <= stage_dp_r;
            end
        end else if (iLOAD) begin
            stage_data_r <= iDATA;
            stage_dp_r   <= iDP;
            pend_r       <= 1'b1;
        end
    end

    assign oDIG  = shadow_data_r[{idx_r, 2'b00} +: 4];
    assign oPEND = pend_r;

endmodule
